phtrack_est_param: RTL

Parametrised pilot-based common-phase estimator for the OFDM receive chain, sitting after the FFT/equaliser and ahead of the phase-correction rotator. It de-rotates and averages NP BPSK pilots per symbol into one complex phase estimate. It optionally smooths that estimate across symbols with a first-order IIR filter. It adds pilot-count checking and a valid/ready output handshake with a holding register.

---
 rtl/phtrack_est_param_if.sv | 32 +++
 rtl/phtrack_est_param.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phtrack_est_param_if.sv
// Bus interface for the pilot-based common-phase estimator: symbol/sample
// input side plus the valid/ready estimate output side.
interface phtrack_est_param_if #(
  parameter int DW = 16
);
  logic          start;
  logic          datin_val;
  logic [DW-1:0] datin_Re;
  logic [DW-1:0] datin_Im;
  logic [1:0]    alloc_vec;
  logic          sym_end;
  logic          mode;
  logic          filt_clr;
  logic [DW-1:0] ph_Re;
  logic [DW-1:0] ph_Im;
  logic          ph_oval;
  logic          ph_ordy;
  logic          ph_drop;
  logic          pcnt_err;

  modport master (
    output start, datin_val, datin_Re, datin_Im, alloc_vec, sym_end,
    output mode, filt_clr, ph_ordy,
    input  ph_Re, ph_Im, ph_oval, ph_drop, pcnt_err
  );

  modport slave (
    input  start, datin_val, datin_Re, datin_Im, alloc_vec, sym_end,
    input  mode, filt_clr, ph_ordy,
    output ph_Re, ph_Im, ph_oval, ph_drop, pcnt_err
  );
endinterface

// File: rtl/phtrack_est_param.sv
// Pilot-based common-phase estimator. De-rotates BPSK pilots, averages NP of
// them per symbol, optionally smooths across symbols with a first-order IIR,
// and presents the estimate through a valid/ready holding register.
module phtrack_est_param #(
  parameter int DW       = 16,
  parameter int LOG2_NP  = 3,
  parameter int ALPHA_SH = 2
) (
  input  logic                clk,
  input  logic                rst,
  phtrack_est_param_if.slave  bus
);

  localparam int AW = DW + LOG2_NP;
  localparam int CW = LOG2_NP + 1;
  localparam logic [CW-1:0] NP_C    = CW'(2**LOG2_NP);
  localparam logic [CW-1:0] NP_M1_C = CW'(2**LOG2_NP - 1);
  localparam logic [DW-1:0] MIN_C   = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] MAX_C   = {1'b0, {(DW-1){1'b1}}};

  localparam logic [1:0] ST_ACC  = 2'd0;
  localparam logic [1:0] ST_AVG  = 2'd1;
  localparam logic [1:0] ST_FILT = 2'd2;

  // Negation that maps the most negative code to the most positive one.
  function automatic logic [DW-1:0] neg_sat(input logic [DW-1:0] x);
    logic [DW-1:0] r;
    if (x == MIN_C) begin
      r = MAX_C;
    end else begin
      r = -x;
    end
    return r;
  endfunction

  function automatic logic [AW-1:0] sext(input logic [DW-1:0] x);
    return {{LOG2_NP{x[DW-1]}}, x};
  endfunction

  // Clamp a DW+1 bit two's-complement value into DW bits.
  function automatic logic [DW-1:0] sat1(input logic [DW:0] x);
    logic [DW-1:0] r;
    if (x[DW] != x[DW-1]) begin
      r = x[DW] ? MIN_C : MAX_C;
    end else begin
      r = x[DW-1:0];
    end
    return r;
  endfunction

  // hist + ((avg - hist) >>> ALPHA_SH), carried at DW+1 bits.
  function automatic logic [DW-1:0] iir_step(input logic [DW-1:0] hist,
                                             input logic [DW-1:0] avg);
    logic signed [DW:0] h, a, d, s, t;
    h = $signed({hist[DW-1], hist});
    a = $signed({avg[DW-1], avg});
    d = a - h;
    s = d >>> ALPHA_SH;
    t = h + s;
    return sat1(t);
  endfunction

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          exc_q, exc_d;
  logic          err_q, err_d;
  logic [AW-1:0] cap_re_q, cap_re_d, cap_im_q, cap_im_d;
  logic [DW-1:0] avg_re_q, avg_re_d, avg_im_q, avg_im_d;
  logic [DW-1:0] hist_re_q, hist_re_d, hist_im_q, hist_im_d;
  logic          hist_empty_q, hist_empty_d;
  logic [DW-1:0] ph_re_q, ph_re_d, ph_im_q, ph_im_d;
  logic          oval_q, oval_d;
  logic          drop_q, drop_d;

  logic          pilot_s, accept_s, last_s, excess_s, short_s;
  logic [DW-1:0] samp_re_s, samp_im_s;
  logic [AW-1:0] sum_re_s, sum_im_s;
  logic          load_s, direct_s;
  logic [DW-1:0] filt_re_s, filt_im_s;

  // Pilot qualification, accumulation and pilot-count checking.
  always_comb begin
    pilot_s = bus.datin_val & ((bus.alloc_vec == 2'b01) | (bus.alloc_vec == 2'b10));
    if (bus.alloc_vec == 2'b10) begin
      samp_re_s = neg_sat(bus.datin_Re);
      samp_im_s = neg_sat(bus.datin_Im);
    end else begin
      samp_re_s = bus.datin_Re;
      samp_im_s = bus.datin_Im;
    end
    accept_s = pilot_s & ~bus.start & (cnt_q < NP_C);
    last_s   = accept_s & (cnt_q == NP_M1_C);
    excess_s = pilot_s & ~bus.start & (cnt_q >= NP_C) & ~exc_q;
    // A same-cycle pilot counts toward the total, so the NP-th pilot with
    // sym_end is a complete symbol.
    short_s  = ~bus.start & bus.datin_val & bus.sym_end & (cnt_q < NP_C) & ~last_s;
    sum_re_s = acc_re_q + sext(samp_re_s);
    sum_im_s = acc_im_q + sext(samp_im_s);

    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    cnt_d    = cnt_q;
    exc_d    = exc_q;
    if (bus.start) begin
      acc_re_d = {AW{1'b0}};
      acc_im_d = {AW{1'b0}};
      cnt_d    = {CW{1'b0}};
      exc_d    = 1'b0;
    end else if (short_s) begin
      acc_re_d = {AW{1'b0}};
      acc_im_d = {AW{1'b0}};
      cnt_d    = {CW{1'b0}};
    end else if (last_s) begin
      // Counter parks at NP so later pilots are flagged as excess.
      acc_re_d = {AW{1'b0}};
      acc_im_d = {AW{1'b0}};
      cnt_d    = NP_C;
    end else if (accept_s) begin
      acc_re_d = sum_re_s;
      acc_im_d = sum_im_s;
      cnt_d    = cnt_q + CW'(1);
    end else if (excess_s) begin
      exc_d    = 1'b1;
    end else begin
      exc_d    = exc_q;
    end
    err_d = short_s | excess_s;
  end

  // Estimate pipeline sequencing: capture, average, then filter.
  always_comb begin
    state_d  = state_q;
    cap_re_d = cap_re_q;
    cap_im_d = cap_im_q;
    avg_re_d = avg_re_q;
    avg_im_d = avg_im_q;
    case (state_q)
      ST_ACC: begin
        if (last_s) begin
          cap_re_d = sum_re_s;
          cap_im_d = sum_im_s;
          state_d  = ST_AVG;
        end else begin
          state_d  = ST_ACC;
        end
      end
      ST_AVG: begin
        // Arithmetic shift: truncation toward -inf.
        avg_re_d = DW'($signed(cap_re_q) >>> LOG2_NP);
        avg_im_d = DW'($signed(cap_im_q) >>> LOG2_NP);
        state_d  = ST_FILT;
      end
      ST_FILT: begin
        state_d  = ST_ACC;
      end
      default: begin
        state_d  = ST_ACC;
      end
    endcase
  end

  // IIR filter, history bookkeeping and the output holding register.
  always_comb begin
    load_s   = (state_q == ST_FILT);
    direct_s = ~bus.mode | hist_empty_q | bus.filt_clr;
    if (direct_s) begin
      filt_re_s = avg_re_q;
      filt_im_s = avg_im_q;
    end else begin
      filt_re_s = iir_step(hist_re_q, avg_re_q);
      filt_im_s = iir_step(hist_im_q, avg_im_q);
    end

    hist_re_d    = hist_re_q;
    hist_im_d    = hist_im_q;
    hist_empty_d = hist_empty_q;
    ph_re_d      = ph_re_q;
    ph_im_d      = ph_im_q;
    oval_d       = oval_q;
    drop_d       = 1'b0;
    if (load_s) begin
      hist_re_d    = filt_re_s;
      hist_im_d    = filt_im_s;
      hist_empty_d = 1'b0;
      ph_re_d      = filt_re_s;
      ph_im_d      = filt_im_s;
      oval_d       = 1'b1;
      drop_d       = oval_q & ~bus.ph_ordy;
    end else begin
      if (bus.filt_clr) begin
        hist_empty_d = 1'b1;
      end else begin
        hist_empty_d = hist_empty_q;
      end
      if (oval_q & bus.ph_ordy) begin
        oval_d = 1'b0;
      end else begin
        oval_d = oval_q;
      end
    end
  end

  // Accumulator, pilot counter and error pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_re_q <= {AW{1'b0}};
      acc_im_q <= {AW{1'b0}};
      cnt_q    <= {CW{1'b0}};
      exc_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      cnt_q    <= cnt_d;
      exc_q    <= exc_d;
      err_q    <= err_d;
    end
  end

  // Pipeline state and stage registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_ACC;
      cap_re_q <= {AW{1'b0}};
      cap_im_q <= {AW{1'b0}};
      avg_re_q <= {DW{1'b0}};
      avg_im_q <= {DW{1'b0}};
    end else begin
      state_q  <= state_d;
      cap_re_q <= cap_re_d;
      cap_im_q <= cap_im_d;
      avg_re_q <= avg_re_d;
      avg_im_q <= avg_im_d;
    end
  end

  // Filter history and output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_re_q    <= {DW{1'b0}};
      hist_im_q    <= {DW{1'b0}};
      hist_empty_q <= 1'b1;
      ph_re_q      <= {DW{1'b0}};
      ph_im_q      <= {DW{1'b0}};
      oval_q       <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      hist_re_q    <= hist_re_d;
      hist_im_q    <= hist_im_d;
      hist_empty_q <= hist_empty_d;
      ph_re_q      <= ph_re_d;
      ph_im_q      <= ph_im_d;
      oval_q       <= oval_d;
      drop_q       <= drop_d;
    end
  end

  assign bus.ph_Re    = ph_re_q;
  assign bus.ph_Im    = ph_im_q;
  assign bus.ph_oval  = oval_q;
  assign bus.ph_drop  = drop_q;
  assign bus.pcnt_err = err_q;

endmodule
